evaluate_sequencer: RTL and testbench

- Sits between the search core and the bank of board evaluators (white/black pawn evaluators and the other term evaluators); all share one broadcast board.
- Accepts one board per valid/ready handshake, launches all evaluators, and waits for every eval_valid.
- Sums the per-evaluator mg/eg terms and tapers them by game phase into one score.
- Clears the evaluators and re-arms them, including the low gap on board_valid that their rising-edge detect requires.

---
 rtl/evaluate_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_evaluate_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evaluate_sequencer.sv
// Evaluation sequencer: broadcasts one board to the evaluator bank, gathers
// every mg/eg term, sums them and tapers the totals by game phase.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module evaluate_sequencer #(
  parameter int EVAL_WIDTH = 22,
  parameter int NUM_EVAL   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           board_in_valid,
  output logic                           board_in_ready,
  input  logic [`BOARD_WIDTH-1:0]        board_in,
  input  logic [8:0]                     phase_in,
  output logic [`BOARD_WIDTH-1:0]        eval_board,
  output logic                           eval_board_valid,
  output logic                           eval_clear,
  input  logic [NUM_EVAL-1:0]            eval_valid_in,
  input  logic [NUM_EVAL*EVAL_WIDTH-1:0] eval_mg_in,
  input  logic [NUM_EVAL*EVAL_WIDTH-1:0] eval_eg_in,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic signed [EVAL_WIDTH-1:0]   result_mg,
  output logic signed [EVAL_WIDTH-1:0]   result_eg,
  output logic signed [EVAL_WIDTH-1:0]   result_score,
  output logic                           result_error
);

  localparam int EW = EVAL_WIDTH;
  localparam int SW = EW + 3;
  localparam int BW = EW + 10;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SUM,
    S_BLEND,
    S_OUT,
    S_CLEAR,
    S_GAP
  } state_t;

  state_t                     state_q;
  logic [CW-1:0]              cnt_q;
  logic [8:0]                 phase_q;
  logic [`BOARD_WIDTH-1:0]    board_q;
  logic [NUM_EVAL*EW-1:0]     mg_q;
  logic [NUM_EVAL*EW-1:0]     eg_q;
  logic                       ready_q;
  logic                       bvalid_q;
  logic                       clear_q;
  logic                       rvalid_q;
  logic                       error_q;
  logic signed [EW-1:0]       res_mg_q;
  logic signed [EW-1:0]       res_eg_q;
  logic signed [EW-1:0]       res_score_q;

  logic [8:0]                 phase_c;
  logic [8:0]                 phase_inv;
  logic signed [SW-1:0]       sum_mg;
  logic signed [SW-1:0]       sum_eg;
  logic signed [BW-1:0]       blend;

  assign phase_c = (phase_in > 9'd256) ? 9'd256 : phase_in;

  always_comb begin
    sum_mg = '0;
    sum_eg = '0;
    for (int i = 0; i < NUM_EVAL; i++) begin
      sum_mg = sum_mg + SW'($signed(mg_q[i*EW +: EW]));
      sum_eg = sum_eg + SW'($signed(eg_q[i*EW +: EW]));
    end
  end

  // Taper works on the already-wrapped sums so score matches result_mg/eg.
  always_comb begin
    phase_inv = 9'd256 - phase_q;
    blend = BW'(res_mg_q) * BW'($signed({1'b0, phase_q}))
          + BW'(res_eg_q) * BW'($signed({1'b0, phase_inv}));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      phase_q     <= '0;
      board_q     <= '0;
      mg_q        <= '0;
      eg_q        <= '0;
      ready_q     <= 1'b1;
      bvalid_q    <= 1'b0;
      clear_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      error_q     <= 1'b0;
      res_mg_q    <= '0;
      res_eg_q    <= '0;
      res_score_q <= '0;
    end else begin
      clear_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (board_in_valid) begin
            board_q  <= board_in;
            phase_q  <= phase_c;
            ready_q  <= 1'b0;
            bvalid_q <= 1'b1;
            state_q  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (&eval_valid_in) begin
            mg_q    <= eval_mg_in;
            eg_q    <= eval_eg_in;
            error_q <= 1'b0;
            state_q <= S_SUM;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            error_q     <= 1'b1;
            res_mg_q    <= '0;
            res_eg_q    <= '0;
            res_score_q <= '0;
            rvalid_q    <= 1'b1;
            state_q     <= S_OUT;
          end
        end
        S_SUM: begin
          res_mg_q <= EW'(sum_mg);
          res_eg_q <= EW'(sum_eg);
          state_q  <= S_BLEND;
        end
        S_BLEND: begin
          res_score_q <= EW'(blend >>> 8);
          rvalid_q    <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (result_ready) begin
            rvalid_q <= 1'b0;
            bvalid_q <= 1'b0;
            clear_q  <= 1'b1;
            state_q  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          state_q <= S_GAP;
        end
        S_GAP: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q  <= 1'b1;
          bvalid_q <= 1'b0;
          rvalid_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign board_in_ready   = ready_q;
  assign eval_board       = board_q;
  assign eval_board_valid = bvalid_q;
  assign eval_clear       = clear_q;
  assign result_valid     = rvalid_q;
  assign result_mg        = res_mg_q;
  assign result_eg        = res_eg_q;
  assign result_score     = res_score_q;
  assign result_error     = error_q;

endmodule

// File: tb/tb_evaluate_sequencer.sv
// Directed bench for evaluate_sequencer: vector table for the arithmetic and
// handshake timing, hand-written sequences for timeout and mid-run reset.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_evaluate_sequencer;

  localparam int EW = 22;
  localparam int NE = 4;
  localparam int BWD = `BOARD_WIDTH;

  logic                   clk;
  logic                   reset;
  logic                   board_in_valid;
  logic                   board_in_ready;
  logic [BWD-1:0]         board_in;
  logic [8:0]             phase_in;
  logic [BWD-1:0]         eval_board;
  logic                   eval_board_valid;
  logic                   eval_clear;
  logic [NE-1:0]          eval_valid_in;
  logic [NE*EW-1:0]       eval_mg_in;
  logic [NE*EW-1:0]       eval_eg_in;
  logic                   result_valid;
  logic                   result_ready;
  logic signed [EW-1:0]   result_mg;
  logic signed [EW-1:0]   result_eg;
  logic signed [EW-1:0]   result_score;
  logic                   result_error;

  evaluate_sequencer #(
    .EVAL_WIDTH(EW),
    .NUM_EVAL(NE),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .board_in_valid(board_in_valid),
    .board_in_ready(board_in_ready),
    .board_in(board_in),
    .phase_in(phase_in),
    .eval_board(eval_board),
    .eval_board_valid(eval_board_valid),
    .eval_clear(eval_clear),
    .eval_valid_in(eval_valid_in),
    .eval_mg_in(eval_mg_in),
    .eval_eg_in(eval_eg_in),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_mg(result_mg),
    .result_eg(result_eg),
    .result_score(result_score),
    .result_error(result_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int clr_cnt = 0;

  always @(posedge clk) if (eval_clear) clr_cnt++;

  typedef struct {
    int mg[4];
    int eg[4];
    int phase;
    int dly;
    int rdy_wait;
    int hold;
    int exp_mg;
    int exp_eg;
    int exp_score;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, board_in_ready, 1);
    chk({tag, "_bvalid"}, eval_board_valid, 0);
    chk({tag, "_clear"}, eval_clear, 0);
    chk({tag, "_rvalid"}, result_valid, 0);
    chk({tag, "_mg"}, result_mg, 0);
    chk({tag, "_eg"}, result_eg, 0);
    chk({tag, "_score"}, result_score, 0);
    chk({tag, "_error"}, result_error, 0);
  endtask

  task automatic load_terms(input vec_t v);
    for (int i = 0; i < NE; i++) begin
      eval_mg_in[i*EW +: EW] = EW'(v.mg[i]);
      eval_eg_in[i*EW +: EW] = EW'(v.eg[i]);
    end
  endtask

  // Accept one board; returns in the LAUNCH cycle.
  task automatic launch(input logic [BWD-1:0] b, input int phase, input int hold);
    int wd;
    board_in = b;
    phase_in = 9'(phase);
    board_in_valid = 1'b1;
    wd = 0;
    while (!board_in_ready && wd < 40) begin
      step();
      wd++;
    end
    chk("accept_ready", board_in_ready, 1);
    chk("idle_bvalid", eval_board_valid, 0);
    step();
    if (hold == 0) board_in_valid = 1'b0;
    chk("launch_bvalid", eval_board_valid, 1);
    chk("launch_ready", board_in_ready, 0);
    chk("launch_board", eval_board == b, 1);
  endtask

  task automatic do_board(input int idx);
    vec_t v;
    int c0;
    logic [BWD-1:0] b;
    v = vecs[idx];
    c0 = clr_cnt;
    b = BWD'(64'hB0A2_0000_0000_0000) + BWD'(idx);
    result_ready = 1'b0;
    eval_valid_in = '0;
    launch(b, v.phase, v.hold);
    load_terms(v);
    for (int i = 0; i < v.dly; i++) begin
      step();
      chk("wait_rvalid", result_valid, 0);
    end
    eval_valid_in = '1;
    step();
    eval_valid_in = '0;
    chk("k1_rvalid", result_valid, 0);
    step();
    chk("k2_rvalid", result_valid, 0);
    if (v.rdy_wait == 0) result_ready = 1'b1;
    step();
    chk("out_rvalid", result_valid, 1);
    chk("out_mg", result_mg, v.exp_mg);
    chk("out_eg", result_eg, v.exp_eg);
    chk("out_score", result_score, v.exp_score);
    chk("out_error", result_error, 0);
    for (int i = 0; i < v.rdy_wait; i++) begin
      step();
      chk("bp_rvalid", result_valid, 1);
      chk("bp_clear", eval_clear, 0);
      chk("bp_bvalid", eval_board_valid, 1);
      chk("bp_ready", board_in_ready, 0);
      chk("bp_score", result_score, v.exp_score);
      chk("bp_mg", result_mg, v.exp_mg);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("clr_pulse", eval_clear, 1);
    chk("clr_rvalid", result_valid, 0);
    chk("clr_bvalid", eval_board_valid, 0);
    chk("clr_ready", board_in_ready, 0);
    step();
    chk("gap_clear", eval_clear, 0);
    chk("gap_bvalid", eval_board_valid, 0);
    chk("gap_ready", board_in_ready, 0);
    step();
    chk("idle_ready", board_in_ready, 1);
    chk("idle_bvalid0", eval_board_valid, 0);
    chk("clear_count", clr_cnt, c0 + 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early;
    int c0;
    vecs[0] = '{mg: '{10, -3, 25, 0}, eg: '{5, 5, -40, 2}, phase: 256, dly: 7,
                rdy_wait: 0, hold: 0, exp_mg: 32, exp_eg: -28, exp_score: 32};
    vecs[1] = '{mg: '{40, 30, 20, 10}, eg: '{-50, -1, 0, 0}, phase: 128, dly: 3,
                rdy_wait: 0, hold: 1, exp_mg: 100, exp_eg: -51, exp_score: 24};
    vecs[2] = '{mg: '{7, 7, 7, 7}, eg: '{-100, 3, -4, 1}, phase: 0, dly: 2,
                rdy_wait: 0, hold: 1, exp_mg: 28, exp_eg: -100, exp_score: -100};
    vecs[3] = '{mg: '{-5, -6, 1, 0}, eg: '{999, 0, 0, 0}, phase: 300, dly: 4,
                rdy_wait: 0, hold: 0, exp_mg: -10, exp_eg: 999, exp_score: -10};
    vecs[4] = '{mg: '{-3, 0, 0, 0}, eg: '{0, 0, 0, 0}, phase: 64, dly: 2,
                rdy_wait: 0, hold: 0, exp_mg: -3, exp_eg: 0, exp_score: -1};
    vecs[5] = '{mg: '{2097151, 1, 0, 0}, eg: '{0, 0, 0, 0}, phase: 256, dly: 5,
                rdy_wait: 1, hold: 0, exp_mg: -2097152, exp_eg: 0,
                exp_score: -2097152};
    vecs[6] = '{mg: '{1000, 0, 0, 0}, eg: '{-1000, 0, 0, 0}, phase: 200, dly: 2,
                rdy_wait: 10, hold: 0, exp_mg: 1000, exp_eg: -1000, exp_score: 562};
    vecs[7] = '{mg: '{1, 2, 3, 4}, eg: '{0, 0, 0, 0}, phase: 256, dly: 1,
                rdy_wait: 0, hold: 0, exp_mg: 10, exp_eg: 0, exp_score: 10};
    vecs[8] = '{mg: '{2, 2, 2, 2}, eg: '{0, 0, 0, 0}, phase: 256, dly: 16,
                rdy_wait: 0, hold: 0, exp_mg: 8, exp_eg: 0, exp_score: 8};

    reset = 1'b1;
    board_in_valid = 1'b0;
    board_in = '0;
    phase_in = '0;
    eval_valid_in = '0;
    eval_mg_in = '0;
    eval_eg_in = '0;
    result_ready = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();
    chk_reset_vals("post_rst");

    for (int i = 0; i < 9; i++) do_board(i);

    // Timeout: evaluators 2 and 3 take turns dropping, never all high at once
    c0 = clr_cnt;
    launch(BWD'(64'hDEAD), 256, 0);
    load_terms(vecs[0]);
    early = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      eval_valid_in = (i % 2 == 0) ? 4'b1011 : 4'b0111;
      step();
      if (i < 16 && result_valid) early = 1'b1;
    end
    eval_valid_in = '0;
    chk("to_early", early, 0);
    chk("to_rvalid", result_valid, 1);
    chk("to_error", result_error, 1);
    chk("to_mg", result_mg, 0);
    chk("to_eg", result_eg, 0);
    chk("to_score", result_score, 0);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("to_clear", eval_clear, 1);
    step();
    step();
    chk("to_idle", board_in_ready, 1);
    chk("to_clr_cnt", clr_cnt, c0 + 1);
    do_board(0);

    // Reset while waiting on evaluators
    c0 = clr_cnt;
    launch(BWD'(64'h1234), 256, 0);
    load_terms(vecs[0]);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("rst_wait");
    eval_valid_in = '1;
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (result_valid || eval_clear) early = 1'b1;
    end
    eval_valid_in = '0;
    chk("rst_wait_spurious", early, 0);
    chk("rst_wait_clr", clr_cnt, c0);

    // Reset while a result is pending
    launch(BWD'(64'h5678), 128, 0);
    load_terms(vecs[1]);
    step();
    eval_valid_in = '1;
    step();
    eval_valid_in = '0;
    step();
    step();
    chk("rst_out_rvalid", result_valid, 1);
    chk("rst_out_score", result_score, 24);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("rst_out");
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (result_valid || eval_clear) early = 1'b1;
    end
    chk("rst_out_spurious", early, 0);
    chk("rst_out_clr", clr_cnt, c0);

    do_board(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
